// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_sb_pkg                                                  |
// | Purpose  : Shared register-file constants used by decode-side blocks:      |
// |            bus widths, register count, zero values and default port counts.|
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial multi-port register file with scoreboard           |
// +----------------------------------------------------------------------------+
package regfile_sb_pkg;

  localparam int unsigned c_reg_addr_bus  = 5;                    // register address width
  localparam int unsigned c_reg_bus       = 32;                   // register data width
  localparam int unsigned c_reg_num       = 2 ** c_reg_addr_bus;  // architectural register count
  localparam logic [c_reg_bus-1:0]      c_zero_word    = '0;
  localparam logic [c_reg_addr_bus-1:0] c_zero_reg     = '0;
  localparam logic                      c_write_enable = 1'b1;
  localparam int unsigned c_reg_rd_ports  = 2;                    // default read port count
  localparam int unsigned c_reg_wr_ports  = 2;                    // default write port count

endpackage : regfile_sb_pkg
`default_nettype wire

// File: rtl/regfile_wr_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_wr_sel                                                  |
// | Purpose  : Resolves which write port (if any) targets one register address.|
// |            Highest-indexed enabled port wins; address 0 never hits.        |
// | Ports    : addr    - register address being resolved                       |
// |            we      - per-port write enables                                |
// |            wr_addr - packed per-port write addresses                       |
// |            wr_data - packed per-port write data                            |
// |            hit     - some enabled port writes addr this cycle              |
// |            data    - data of the winning port (0 when no hit)              |
// | Revision : 1.0  initial version                                            |
// +----------------------------------------------------------------------------+
module regfile_wr_sel
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = c_reg_bus,
  parameter int ADDR_W = c_reg_addr_bus,
  parameter int NUM_WR = c_reg_wr_ports
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  // Ascending scan: a later (higher-indexed) matching port overwrites an
  // earlier one, which gives the highest port priority.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if ((we[p] == c_write_enable) && (addr != '0) &&
          (wr_addr[p*ADDR_W +: ADDR_W] == addr)) begin
        hit  = 1'b1;
        data = wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

endmodule : regfile_wr_sel
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_sb                                                      |
// | Purpose  : Multi-port integer register file with write-to-read bypass and |
// |            a per-register pending (busy) scoreboard for issue stalls.      |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            rd_addr/rd_data/rd_busy - NUM_RD combinational read ports       |
// |            we/wr_addr/wr_data      - NUM_WR write ports, top port wins     |
// |            rsv_en/rsv_addr         - mark a destination register pending   |
// |            flush                   - drop every pending mark               |
// |            busy_cnt                - registered count of pending registers |
// | Revision : 1.0  initial version                                            |
// +----------------------------------------------------------------------------+
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = c_reg_bus,
  parameter int ADDR_W = c_reg_addr_bus,
  parameter int NUM_RD = c_reg_rd_ports,
  parameter int NUM_WR = c_reg_wr_ports
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  // Entry 0 is only ever reset, so it reads as zero without a special case.
  logic [DATA_W-1:0] r_mem [NREG];
  logic [NREG-1:0]   r_busy;
  logic [ADDR_W:0]   r_busy_cnt;

  logic [NREG-1:0]   w_reg_hit;
  logic [DATA_W-1:0] w_reg_data [NREG];
  logic [NREG-1:0]   w_busy_nxt;
  logic [ADDR_W:0]   w_busy_cnt_nxt;
  logic [NUM_RD-1:0] w_rd_hit;
  logic [DATA_W-1:0] w_rd_wdata [NUM_RD];

  // Per-register write resolution; the instance for address 0 never hits.
  for (genvar k = 0; k < NREG; k++) begin : g_reg
    regfile_wr_sel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_wr_sel (
      .addr    (ADDR_W'(k)),
      .we      (we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hit     (w_reg_hit[k]),
      .data    (w_reg_data[k])
    );
  end

  // Per-read-port bypass: a same-cycle write overrides the array and also
  // masks the busy bit, since that write resolves the pending producer.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_wr_sel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_byp_sel (
      .addr    (rd_addr[i*ADDR_W +: ADDR_W]),
      .we      (we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hit     (w_rd_hit[i]),
      .data    (w_rd_wdata[i])
    );

    assign rd_data[i*DATA_W +: DATA_W] = w_rd_hit[i] ? w_rd_wdata[i]
                                                     : r_mem[rd_addr[i*ADDR_W +: ADDR_W]];
    assign rd_busy[i] = r_busy[rd_addr[i*ADDR_W +: ADDR_W]] & ~w_rd_hit[i];
  end

  // Next busy vector: clear on write, then set on reservation so a younger
  // producer issued in the same cycle keeps the register pending. Flush
  // overrides both.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int k = 1; k < NREG; k++) begin
      if (w_reg_hit[k]) begin
        w_busy_nxt[k] = 1'b0;
      end
      if (rsv_en && (rsv_addr == ADDR_W'(k))) begin
        w_busy_nxt[k] = 1'b1;
      end
    end
    if (flush) begin
      w_busy_nxt = '0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Count from the next-state vector so busy_cnt and busy update together.
  always_comb begin
    w_busy_cnt_nxt = '0;
    for (int k = 0; k < NREG; k++) begin
      w_busy_cnt_nxt = w_busy_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        r_mem[k] <= '0;
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      for (int k = 1; k < NREG; k++) begin
        if (w_reg_hit[k]) begin
          r_mem[k] <= w_reg_data[k];
        end
      end
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
    end
  end

  assign busy_cnt = r_busy_cnt;

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_regfile_sb                                                   |
// | Purpose  : Self-checking bench for regfile_sb: directed vectors on the     |
// |            default configuration plus a reference-model sweep on a         |
// |            NUM_RD=3 / NUM_WR=1 / ADDR_W=4 instance.                        |
// | Revision : 1.0  initial version                                            |
// +----------------------------------------------------------------------------+
module tb_regfile_sb;

  logic clk;
  logic rst_n;

  // Default instance (DATA_W=32, ADDR_W=5, NUM_RD=2, NUM_WR=2)
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_we;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_rsv_en;
  logic [4:0]  a_rsv_addr;
  logic        a_flush;
  logic [5:0]  a_busy_cnt;

  // Sweep instance (DATA_W=32, ADDR_W=4, NUM_RD=3, NUM_WR=1)
  logic [11:0] b_rd_addr;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic [0:0]  b_we;
  logic [3:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_rsv_en;
  logic [3:0]  b_rsv_addr;
  logic        b_flush;
  logic [4:0]  b_busy_cnt;

  int n_asserts;
  int n_fail;

  regfile_sb #(
    .DATA_W (32), .ADDR_W (5), .NUM_RD (2), .NUM_WR (2)
  ) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (a_rd_addr),
    .rd_data  (a_rd_data),
    .rd_busy  (a_rd_busy),
    .we       (a_we),
    .wr_addr  (a_wr_addr),
    .wr_data  (a_wr_data),
    .rsv_en   (a_rsv_en),
    .rsv_addr (a_rsv_addr),
    .flush    (a_flush),
    .busy_cnt (a_busy_cnt)
  );

  regfile_sb #(
    .DATA_W (32), .ADDR_W (4), .NUM_RD (3), .NUM_WR (1)
  ) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (b_rd_addr),
    .rd_data  (b_rd_data),
    .rd_busy  (b_rd_busy),
    .we       (b_we),
    .wr_addr  (b_wr_addr),
    .wr_data  (b_wr_data),
    .rsv_en   (b_rsv_en),
    .rsv_addr (b_rsv_addr),
    .flush    (b_flush),
    .busy_cnt (b_busy_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // later in the same cycle, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_we       = '0;
    a_wr_addr  = '0;
    a_wr_data  = '0;
    a_rsv_en   = 1'b0;
    a_rsv_addr = '0;
    a_flush    = 1'b0;
  endtask

  task automatic a_wr(input int p, input logic [4:0] addr, input logic [31:0] data);
    a_we[p]             = 1'b1;
    a_wr_addr[p*5 +: 5]  = addr;
    a_wr_data[p*32 +: 32] = data;
  endtask

  task automatic a_rsv(input logic [4:0] addr);
    a_rsv_en   = 1'b1;
    a_rsv_addr = addr;
  endtask

  task automatic a_rd(input int p, input logic [4:0] addr);
    a_rd_addr[p*5 +: 5] = addr;
  endtask

  // Reference model for the sweep instance
  logic [31:0] m_mem [16];
  logic [15:0] m_busy;

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int k = 0; k < 16; k++) c = c + 5'(v[k]);
    return c;
  endfunction

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    a_rd_addr = '0;
    a_idle();
    b_rd_addr = '0;
    b_we = '0; b_wr_addr = '0; b_wr_data = '0;
    b_rsv_en = 1'b0; b_rsv_addr = '0; b_flush = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    a_rd(0, 5'd5); a_rd(1, 5'd31);
    #1;
    check("rst_rd_data", a_rd_data, 64'h0);
    check("rst_rd_busy", 64'(a_rd_busy), 64'h0);
    check("rst_busy_cnt", 64'(a_busy_cnt), 64'h0);
    rst_n = 1'b1;
    tick();

    // ---------------- write / read with bypass ----------------
    a_wr(0, 5'd5, 32'hDEADBEEF);
    a_rd(0, 5'd5);
    #2;
    check("byp_addr5", 64'(a_rd_data[31:0]), 64'hDEADBEEF);
    tick();
    a_idle();
    #1;
    check("arr_addr5", 64'(a_rd_data[31:0]), 64'hDEADBEEF);

    // ---------------- x0 hard-wired ----------------
    a_wr(0, 5'd0, 32'h1234);
    a_rd(0, 5'd0);
    #2;
    check("x0_byp", 64'(a_rd_data[31:0]), 64'h0);
    tick();
    a_idle();
    #1;
    check("x0_arr", 64'(a_rd_data[31:0]), 64'h0);

    // ---------------- write conflict ----------------
    a_wr(0, 5'd7, 32'h11);
    a_wr(1, 5'd7, 32'h22);
    a_rd(1, 5'd7);
    #2;
    check("conf_byp", 64'(a_rd_data[63:32]), 64'h22);
    tick();
    a_idle();
    #1;
    check("conf_arr", 64'(a_rd_data[63:32]), 64'h22);

    // ---------------- scoreboard set ----------------
    a_rsv(5'd9);
    a_rd(0, 5'd9);
    #2;
    check("rsv_same_cyc", 64'(a_rd_busy[0]), 64'h0);
    tick();
    a_idle();
    #1;
    check("rsv_busy", 64'(a_rd_busy[0]), 64'h1);
    check("rsv_cnt", 64'(a_busy_cnt), 64'h1);

    // ---------------- scoreboard clear by write ----------------
    a_wr(1, 5'd9, 32'h99);
    #2;
    check("clr_busy_wcyc", 64'(a_rd_busy[0]), 64'h0);
    check("clr_cnt_wcyc", 64'(a_busy_cnt), 64'h1);
    tick();
    a_idle();
    #1;
    check("clr_cnt", 64'(a_busy_cnt), 64'h0);
    check("clr_busy", 64'(a_rd_busy[0]), 64'h0);

    // ---------------- set wins over clear ----------------
    a_rsv(5'd9);
    a_wr(0, 5'd9, 32'hAA);
    tick();
    a_idle();
    #1;
    check("setwin_busy", 64'(a_rd_busy[0]), 64'h1);
    check("setwin_cnt", 64'(a_busy_cnt), 64'h1);
    check("setwin_data", 64'(a_rd_data[31:0]), 64'hAA);
    a_wr(0, 5'd9, 32'hAB);
    tick();
    a_idle();

    // ---------------- flush ----------------
    a_wr(0, 5'd3, 32'h33);
    a_wr(1, 5'd4, 32'h44);
    tick();
    a_idle();
    a_rsv(5'd3); tick();
    a_rsv(5'd4); tick();
    a_rsv(5'd5); tick();
    a_idle();
    #1;
    check("pre_flush_cnt", 64'(a_busy_cnt), 64'h3);
    a_flush = 1'b1;
    a_rsv(5'd6);
    tick();
    a_idle();
    a_rd(0, 5'd3); a_rd(1, 5'd4);
    #1;
    check("flush_cnt", 64'(a_busy_cnt), 64'h0);
    check("flush_busy_3_4", 64'(a_rd_busy), 64'h0);
    check("flush_data_3_4", a_rd_data, {32'h44, 32'h33});
    a_rd(0, 5'd5); a_rd(1, 5'd6);
    #1;
    check("flush_busy_5_6", 64'(a_rd_busy), 64'h0);
    check("flush_data_5", 64'(a_rd_data[31:0]), 64'hDEADBEEF);

    // ---------------- asynchronous reset mid-cycle ----------------
    tick();
    a_rsv(5'd3);
    tick();
    a_idle();
    a_rd(0, 5'd3); a_rd(1, 5'd5);
    #1;
    check("pre_rst_busy", 64'(a_rd_busy[0]), 64'h1);
    check("pre_rst_data", 64'(a_rd_data[63:32]), 64'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check("arst_data", a_rd_data, 64'h0);
    check("arst_busy", 64'(a_rd_busy), 64'h0);
    check("arst_cnt", 64'(a_busy_cnt), 64'h0);
    a_wr(0, 5'd5, 32'h77);
    tick();
    a_idle();
    rst_n = 1'b1;
    #1;
    check("no_wr_in_rst", 64'(a_rd_data[63:32]), 64'h0);

    // ---------------- parameter sweep against reference model ----------------
    for (int k = 0; k < 16; k++) m_mem[k] = '0;
    m_busy = '0;
    check("b_reset_cnt", 64'(b_busy_cnt), 64'h0);
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      b_we       = 1'($urandom_range(0, 3) != 0);
      b_wr_addr  = 4'($urandom_range(0, 15));
      b_wr_data  = $urandom;
      b_rsv_en   = 1'($urandom_range(0, 1));
      b_rsv_addr = 4'($urandom_range(0, 15));
      b_flush    = 1'($urandom_range(0, 31) == 0);
      for (int p = 0; p < 3; p++) begin
        // Bias one port toward the write address to exercise the bypass.
        if (p == 0 && $urandom_range(0, 1) == 1) b_rd_addr[p*4 +: 4] = b_wr_addr;
        else b_rd_addr[p*4 +: 4] = 4'($urandom_range(0, 15));
      end
      #2;
      for (int p = 0; p < 3; p++) begin
        logic [3:0]  ra;
        logic        hit;
        logic [31:0] exp_d;
        ra    = b_rd_addr[p*4 +: 4];
        hit   = b_we[0] && (b_wr_addr == ra) && (ra != 4'd0);
        exp_d = (ra == 4'd0) ? 32'h0 : (hit ? b_wr_data : m_mem[ra]);
        check("b_rd_data", 64'(b_rd_data[p*32 +: 32]), 64'(exp_d));
        check("b_rd_busy", 64'(b_rd_busy[p]), 64'(m_busy[ra] && !hit));
      end
      @(posedge clk);
      if (b_we[0] && b_wr_addr != 4'd0) begin
        m_mem[b_wr_addr]  = b_wr_data;
        m_busy[b_wr_addr] = 1'b0;
      end
      if (b_flush) m_busy = '0;
      else if (b_rsv_en && b_rsv_addr != 4'd0) m_busy[b_rsv_addr] = 1'b1;
      #1;
      check("b_busy_cnt", 64'(b_busy_cnt), 64'(popcnt16(m_busy)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_regfile_sb
`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with write-to-read bypass and a per-register pending scoreboard. It replaces the fixed 2-read/1-write register file of the decode stage. Decode reads operands through it, writeback/load-return paths write through it, and issue logic uses the scoreboard to stall on unresolved producers.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register address width; register count NREG = 2**ADDR_W
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports; port NUM_WR-1 has highest priority

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, bypassed
- rd_busy  out  NUM_RD  selected register pending and not resolved this cycle
- we  in  NUM_WR  write enables
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- rsv_en  in  1  mark rsv_addr pending (instruction issued with destination rsv_addr)
- rsv_addr  in  ADDR_W  register to reserve
- flush  in  1  clear all pending bits; data untouched
- busy_cnt  out  ADDR_W+1  number of pending registers, registered

## Operation
- Register 0 is hard-wired: reads return 0, writes are ignored, reservations are ignored, and it is never busy.
- Write: on each rising edge, every port with we=1 and a nonzero address updates its register. If several ports target the same address, the highest-indexed port wins.
- Read: rd_data[i] is combinational.
  - If any enabled write port targets rd_addr[i] (nonzero) this cycle, the output is that write's data, using the same winner rule (bypass).
  - Otherwise the output is the array contents.
- Scoreboard: busy[NREG-1:1] register bits.
  - Clear: a write to address a clears busy[a] at the edge.
  - Set: rsv_en with nonzero rsv_addr sets busy[rsv_addr] at the edge.
  - Set and clear of the same register in the same cycle: set wins, because the new producer is younger.
  - flush=1 clears all busy bits at the edge. A rsv_en asserted in the same cycle is dropped, since flush wins.
- rd_busy[i] = busy[rd_addr[i]] && !(write to rd_addr[i] this cycle). It is combinational, and 0 for address 0.
- busy_cnt is the registered popcount of busy after the edge update. Its range is 0..NREG-1.
- A write to a non-busy register is legal; it updates data and leaves busy at 0.

## Timing
- Reset (rst_n=0, asynchronous): all registers become 0, all busy bits 0, and busy_cnt 0.
  - rd_data reflects the reset array (0) immediately, unless a write is bypassed.
  - rd_busy is 0.
- Reset deassertion mid-operation: state resumes from all-zero. No writes are accepted while rst_n=0.
- Read latency is 0 cycles; the bypass makes a write visible to a read in the same cycle.
- Write-to-array latency is 1 edge.
- rsv_en takes effect at the next edge. rd_busy for the reserved register goes 1 in the following cycle.
- busy_cnt lags the busy bits by 0 cycles; both are registered at the same edge.
- No handshakes: all inputs are sampled every cycle, and the caller guarantees address validity.

## Structure
- Shared defines header (existing): RegAddrBus, RegBus, RegNum, ZeroWord, ZeroReg, WriteEnable.
  - Add RegRdPorts and RegWrPorts defaults there.
- Sub-module regfile_wr_sel: given one address plus the we/wr_addr/wr_data vectors, it outputs hit and the winning data.
  - Instantiate once per read port for the bypass and the rd_busy mask.
  - Reuse it per register for array/scoreboard write resolution.
- Top level: generate loops over ports, a busy vector, and a popcount.

## Test plan
- Reset: load several registers, assert rst_n=0 mid-cycle → all rd_data=0, rd_busy=0, busy_cnt=0 without waiting for a clock edge.
- Write/read and x0:
  - we[0]=1, addr 5, data 0xDEADBEEF → rd_data for addr 5 equals 0xDEADBEEF in the same cycle (bypass) and after the edge (array).
  - Write of 0x1234 to addr 0 → reads of addr 0 return 0.
- Write conflict: port0 writes addr 7=0x11, port1 writes addr 7=0x22 in the same cycle → bypass shows 0x22 and the array holds 0x22.
- Scoreboard:
  - rsv addr 9 → next cycle rd_busy=1 and busy_cnt=1.
  - Write addr 9 → rd_busy=0 in the write cycle, busy_cnt=0 after the edge.
  - rsv 9 together with a write to 9 in the same cycle → busy stays 1.
- Flush: reserve addrs 3, 4 and 5, then flush=1 with rsv_en on addr 6 → busy_cnt=0, and all four registers not busy. Data of 3..5 is unchanged.
- Parameter sweep: NUM_RD=3, NUM_WR=1, ADDR_W=4 → random writes and reads checked against a reference model for 10k cycles.
